// File: rtl/eth_pkg.sv
// Shared definitions for the UDP channel demultiplexer: FSM state encoding,
// well-known payload flags and sizing constants.
package eth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FLAG = 2'd1,
    ST_FWD  = 2'd2,
    ST_DROP = 2'd3
  } state_e;

  localparam logic [31:0] FLAG_MOTOR = 32'hE1EC_0C0D;
  localparam logic [31:0] FLAG_AD    = 32'hAD86_86DA;

  // Number of leading payload bytes that form the channel flag
  localparam int unsigned FLAG_BYTES = 4;
  // Width of the flag byte counter (counts 0..FLAG_BYTES-1)
  localparam int unsigned BCNT_W     = 2;
  // Width of the channel index; covers up to 8 channels
  localparam int unsigned SEL_W      = 3;

endpackage

// File: rtl/udp_flag_match.sv
// Combinational flag lookup: compares a 32-bit flag against NUM_CH channel
// flags and returns the lowest matching channel index.
// Ports:
//   flag   in   32-bit big-endian flag assembled from payload bytes 0..3
//   hit_c  out  at least one channel flag matches
//   idx_c  out  lowest matching channel index (0 when no match)
module udp_flag_match
  import eth_pkg::*;
#(
  parameter int unsigned          NUM_CH   = 2,
  parameter logic [NUM_CH*32-1:0] CH_FLAGS = {FLAG_AD, FLAG_MOTOR}
) (
  input  logic [31:0]      flag,
  output logic             hit_c,
  output logic [SEL_W-1:0] idx_c
);

  // Scan from the top down so the lowest matching index is the last writer
  always_comb begin
    hit_c = 1'b0;
    idx_c = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (flag == CH_FLAGS[32*i +: 32]) begin
        hit_c = 1'b1;
        idx_c = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/udp_chan_demux.sv
// UDP payload demultiplexer. The first four payload bytes form a flag that
// selects an output channel; the remaining bytes are forwarded on that
// channel through a one-byte hold register. Unknown flags and short payloads
// are discarded, and an input-stall watchdog truncates stalled packets.
// Optional per-channel packet counters are built when UDP_CHAN_DEMUX_STATS_EN
// is defined.
// Ports:
//   sys_clk, sys_rst_n        clock, synchronous active-low reset
//   s_data/s_valid/s_last     input byte stream, s_ready accepts
//   m_data/m_last             shared output byte and end-of-packet
//   m_valid/m_ready           one-hot per-channel handshake
//   drop_pulse                one cycle per discarded packet
//   timeout_pulse             one cycle per watchdog-truncated packet
//   ch_pkt_cnt                per-channel 16-bit packet counters (stats build)
module udp_chan_demux
  import eth_pkg::*;
#(
  parameter int unsigned          NUM_CH          = 2,
  parameter logic [NUM_CH*32-1:0] CH_FLAGS        = {FLAG_AD, FLAG_MOTOR},
  parameter int unsigned          WATCH_DOG_WIDTH = 12
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [7:0]        m_data,
  output logic [NUM_CH-1:0] m_valid,
  output logic              m_last,
  input  logic [NUM_CH-1:0] m_ready,
  output logic              drop_pulse,
  output logic              timeout_pulse
`ifdef UDP_CHAN_DEMUX_STATS_EN
  ,
  output logic [NUM_CH*16-1:0] ch_pkt_cnt
`endif
);

  state_e                     state_q, state_d;
  logic [BCNT_W-1:0]          bcnt_q, bcnt_d;
  logic [23:0]                flag_sr_q, flag_sr_d;
  logic [SEL_W-1:0]           sel_q, sel_d;
  logic [7:0]                 hold_data_q, hold_data_d;
  logic                       hold_last_q, hold_last_d;
  logic                       hold_full_q, hold_full_d;
  logic [WATCH_DOG_WIDTH-1:0] wd_cnt_q, wd_cnt_d;
  logic                       wd_drop_q, wd_drop_d;
  logic                       drop_pulse_q, drop_pulse_d;
  logic                       timeout_pulse_q, timeout_pulse_d;

  logic                       hit_c;
  logic [SEL_W-1:0]           idx_c;
  logic [NUM_CH-1:0]          sel_oh_c;
  logic                       sel_ready_c;
  logic                       wd_expired_c;
  logic                       fire_c;
  logic                       hs_c;
  logic                       accept_c;

  // Flag of the byte being accepted, valid when it is byte 3
  udp_flag_match #(
    .NUM_CH   (NUM_CH),
    .CH_FLAGS (CH_FLAGS)
  ) u_flag_match (
    .flag  ({flag_sr_q, s_data}),
    .hit_c (hit_c),
    .idx_c (idx_c)
  );

  always_comb begin
    sel_oh_c = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      sel_oh_c[i] = (sel_q == SEL_W'(i));
    end
  end

  assign sel_ready_c  = |(m_ready & sel_oh_c);
  assign wd_expired_c = (wd_cnt_q == {WATCH_DOG_WIDTH{1'b1}});
  // Hold byte is offered once its successor arrives, it is the last, or the watchdog fires
  assign fire_c       = (state_q == ST_FWD) & hold_full_q &
                        (hold_last_q | s_valid | wd_expired_c);
  assign hs_c         = fire_c & sel_ready_c;
  assign accept_c     = s_valid & s_ready;

  // State register
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      bcnt_q          <= '0;
      flag_sr_q       <= '0;
      sel_q           <= '0;
      hold_data_q     <= '0;
      hold_last_q     <= 1'b0;
      hold_full_q     <= 1'b0;
      wd_cnt_q        <= '0;
      wd_drop_q       <= 1'b0;
      drop_pulse_q    <= 1'b0;
      timeout_pulse_q <= 1'b0;
    end else begin
      bcnt_q          <= bcnt_d;
      flag_sr_q       <= flag_sr_d;
      sel_q           <= sel_d;
      hold_data_q     <= hold_data_d;
      hold_last_q     <= hold_last_d;
      hold_full_q     <= hold_full_d;
      wd_cnt_q        <= wd_cnt_d;
      wd_drop_q       <= wd_drop_d;
      drop_pulse_q    <= drop_pulse_d;
      timeout_pulse_q <= timeout_pulse_d;
    end
  end

  // Next state and datapath update
  always_comb begin
    state_d         = state_q;
    bcnt_d          = bcnt_q;
    flag_sr_d       = flag_sr_q;
    sel_d           = sel_q;
    hold_data_d     = hold_data_q;
    hold_last_d     = hold_last_q;
    hold_full_d     = hold_full_q;
    wd_drop_d       = wd_drop_q;
    wd_cnt_d        = '0;
    drop_pulse_d    = 1'b0;
    timeout_pulse_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          flag_sr_d = 24'(s_data);
          bcnt_d    = BCNT_W'(1);
          // A one-byte payload is too short to carry a flag
          if (s_last) drop_pulse_d = 1'b1;
          else        state_d      = ST_FLAG;
        end
      end

      ST_FLAG: begin
        if (accept_c) begin
          flag_sr_d = {flag_sr_q[15:0], s_data};
          bcnt_d    = bcnt_q + BCNT_W'(1);
          if (s_last) begin
            drop_pulse_d = 1'b1;
            state_d      = ST_IDLE;
          end else if (bcnt_q == BCNT_W'(FLAG_BYTES - 1)) begin
            if (hit_c) begin
              sel_d   = idx_c;
              state_d = ST_FWD;
            end else begin
              wd_drop_d = 1'b0;
              state_d   = ST_DROP;
            end
          end
        end else if (wd_expired_c) begin
          wd_drop_d = 1'b1;
          state_d   = ST_DROP;
        end
      end

      ST_FWD: begin
        if (hs_c && hold_last_q) begin
          hold_full_d = 1'b0;
          hold_last_d = 1'b0;
          state_d     = ST_IDLE;
        end else if (hs_c && wd_expired_c) begin
          // Truncated byte is out; a byte taken in the same cycle belongs to the discarded tail
          timeout_pulse_d = 1'b1;
          hold_full_d     = 1'b0;
          hold_last_d     = 1'b0;
          wd_drop_d       = 1'b1;
          state_d         = (accept_c && s_last) ? ST_IDLE : ST_DROP;
        end else if (accept_c) begin
          hold_data_d = s_data;
          hold_last_d = s_last;
          hold_full_d = 1'b1;
        end else if (hs_c) begin
          hold_full_d = 1'b0;
        end
      end

      ST_DROP: begin
        if (accept_c && s_last) begin
          drop_pulse_d = !wd_drop_q;
          state_d      = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Watchdog: consecutive idle-input cycles while a packet is open, saturating
    if ((state_d == state_q) && !s_valid &&
        ((state_q == ST_FLAG) ||
         ((state_q == ST_FWD) && hold_full_q && !hold_last_q))) begin
      wd_cnt_d = wd_expired_c ? wd_cnt_q : wd_cnt_q + WATCH_DOG_WIDTH'(1);
    end
  end

  // Outputs
  always_comb begin
    s_ready = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_FLAG, ST_DROP: s_ready = 1'b1;
      ST_FWD:  s_ready = !hold_last_q & (!hold_full_q | hs_c);
      default: s_ready = 1'b0;
    endcase
    s_ready       = s_ready & sys_rst_n;
    m_valid       = fire_c ? sel_oh_c : '0;
    m_data        = hold_data_q;
    m_last        = (state_q == ST_FWD) & hold_full_q & (hold_last_q | wd_expired_c);
    drop_pulse    = drop_pulse_q;
    timeout_pulse = timeout_pulse_q;
  end

`ifdef UDP_CHAN_DEMUX_STATS_EN
  logic [15:0] cnt_q [NUM_CH];
  logic [15:0] cnt_d [NUM_CH];

  // Count every end-of-packet handshake, truncated ones included; wraps naturally
  always_comb begin
    for (int i = 0; i < int'(NUM_CH); i++) begin
      cnt_d[i] = cnt_q[i];
      if (hs_c && m_last && sel_oh_c[i]) cnt_d[i] = cnt_q[i] + 16'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (!sys_rst_n) cnt_q[i] <= '0;
      else            cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < int'(NUM_CH); i++) begin
      ch_pkt_cnt[16*i +: 16] = cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_udp_chan_demux.sv
// Directed bench for udp_chan_demux (2 channels, 4-bit watchdog).
module tb_udp_chan_demux;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [7:0] s_data    = 8'h00;
  logic       s_valid   = 1'b0;
  logic       s_last    = 1'b0;
  logic       s_ready;
  logic [7:0] m_data;
  logic [1:0] m_valid;
  logic       m_last;
  logic [1:0] m_ready;
  logic       drop_pulse;
  logic       timeout_pulse;
`ifdef UDP_CHAN_DEMUX_STATS_EN
  logic [31:0] ch_pkt_cnt;
`endif

  logic tog_en = 1'b0;
  logic tog_ph = 1'b0;
  assign m_ready = {tog_en ? tog_ph : 1'b1, 1'b1};

  int n_pass  = 0;
  int n_total = 0;

  // Output monitor state
  logic [7:0] ob_data[$];
  bit         ob_last[$];
  int         ob_ch[$];
  int         n_drop, n_to, n_mv0, n_mv_any, n_stall;

  udp_chan_demux #(
    .NUM_CH          (2),
    .CH_FLAGS        (64'hAD86_86DA_E1EC_0C0D),
    .WATCH_DOG_WIDTH (4)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_last        (s_last),
    .s_ready       (s_ready),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_last        (m_last),
    .m_ready       (m_ready),
    .drop_pulse    (drop_pulse),
`ifdef UDP_CHAN_DEMUX_STATS_EN
    .ch_pkt_cnt    (ch_pkt_cnt),
`endif
    .timeout_pulse (timeout_pulse)
  );

  always #5 sys_clk = ~sys_clk;

  initial forever begin
    @(posedge sys_clk);
    #1;
    tog_ph = ~tog_ph;
  end

  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (drop_pulse)    n_drop++;
      if (timeout_pulse) n_to++;
      if (m_valid[0])    n_mv0++;
      if (|m_valid)      n_mv_any++;
      for (int c = 0; c < 2; c++) begin
        if (m_valid[c] && m_ready[c]) begin
          ob_data.push_back(m_data);
          ob_last.push_back(m_last);
          ob_ch.push_back(c);
        end
      end
    end
  end

  task automatic clr_mon();
    ob_data.delete();
    ob_last.delete();
    ob_ch.delete();
    n_drop = 0; n_to = 0; n_mv0 = 0; n_mv_any = 0; n_stall = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int w = 0;
    s_data = d; s_last = l; s_valid = 1'b1;
    @(negedge sys_clk);
    while (!s_ready && w < 40) begin
      w++; n_stall++;
      @(negedge sys_clk);
    end
    n_total++;
    if (s_ready !== 1'b1) $display("FAIL send_wait: s_ready=%b after %0d cycles, required 1", s_ready, w);
    else n_pass++;
    @(posedge sys_clk);
    #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  // Bytes 0..3 are the flag, payload bytes are 01,02,...; optional input gap after byte gap_after
  task automatic send_pkt(input logic [31:0] flag, input int total, input int gap_after, input int gap);
    logic [7:0] b;
    for (int k = 0; k < total; k++) begin
      if (k < 4) b = flag[31-8*k -: 8];
      else       b = 8'(k - 3);
      send_byte(b, k == total - 1);
      if (k == gap_after) begin
        repeat (gap) @(posedge sys_clk);
        #1;
      end
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    n_total++; if (m_valid !== 2'b00) $display("FAIL rst_m_valid: got %b want 00", m_valid); else n_pass++;
    n_total++; if (m_last !== 1'b0) $display("FAIL rst_m_last: got %b want 0", m_last); else n_pass++;
    n_total++; if (m_data !== 8'h00) $display("FAIL rst_m_data: got %h want 00", m_data); else n_pass++;
    n_total++; if (drop_pulse !== 1'b0) $display("FAIL rst_drop: got %b want 0", drop_pulse); else n_pass++;
    n_total++; if (timeout_pulse !== 1'b0) $display("FAIL rst_timeout: got %b want 0", timeout_pulse); else n_pass++;
    n_total++; if (s_ready !== 1'b0) $display("FAIL rst_s_ready: got %b want 0", s_ready); else n_pass++;
`ifdef UDP_CHAN_DEMUX_STATS_EN
    n_total++; if (ch_pkt_cnt !== 32'h0) $display("FAIL rst_cnt: got %h want 0", ch_pkt_cnt); else n_pass++;
`endif
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    n_total++; if (s_ready !== 1'b1) $display("FAIL rel_s_ready: got %b want 1", s_ready); else n_pass++;
    idle(1);
  endtask

  task automatic test_fwd_ch0();
    clr_mon();
    send_pkt(32'hE1EC0C0D, 10, -1, 0);
    idle(6);
    n_total++; if (ob_data.size() != 6) $display("FAIL ch0_beats: got %0d want 6", ob_data.size()); else n_pass++;
    for (int i = 0; i < ob_data.size() && i < 6; i++) begin
      n_total++;
      if (ob_ch[i] != 0 || ob_data[i] !== 8'(i + 1) || ob_last[i] != (i == 5))
        $display("FAIL ch0_beat%0d: got ch%0d %h last=%0d want ch0 %h last=%0d",
                 i, ob_ch[i], ob_data[i], ob_last[i], 8'(i + 1), (i == 5));
      else n_pass++;
    end
    n_total++; if (n_drop != 0 || n_to != 0) $display("FAIL ch0_pulses: drop=%0d to=%0d want 0 0", n_drop, n_to); else n_pass++;
  endtask

  task automatic test_backpressure();
    clr_mon();
    tog_en = 1'b1;
    send_pkt(32'hAD8686DA, 7, -1, 0);
    idle(10);
    tog_en = 1'b0;
    n_total++; if (ob_data.size() != 3) $display("FAIL bp_beats: got %0d want 3", ob_data.size()); else n_pass++;
    for (int i = 0; i < ob_data.size() && i < 3; i++) begin
      n_total++;
      if (ob_ch[i] != 1 || ob_data[i] !== 8'(i + 1) || ob_last[i] != (i == 2))
        $display("FAIL bp_beat%0d: got ch%0d %h last=%0d want ch1 %h last=%0d",
                 i, ob_ch[i], ob_data[i], ob_last[i], 8'(i + 1), (i == 2));
      else n_pass++;
    end
    n_total++; if (n_mv0 != 0) $display("FAIL bp_mv0: got %0d cycles want 0", n_mv0); else n_pass++;
  endtask

  task automatic test_drop();
    clr_mon();
    send_pkt(32'h12345678, 14, -1, 0);
    idle(4);
    n_total++; if (n_mv_any != 0) $display("FAIL drop_mvalid: got %0d cycles want 0", n_mv_any); else n_pass++;
    n_total++; if (n_stall != 0) $display("FAIL drop_s_ready: stalled %0d cycles want 0", n_stall); else n_pass++;
    n_total++; if (n_drop != 1) $display("FAIL drop_pulse: got %0d want 1", n_drop); else n_pass++;
    clr_mon();
    send_pkt(32'hE1EC0C0D, 6, -1, 0);
    idle(5);
    n_total++; if (ob_data.size() != 2) $display("FAIL after_drop_beats: got %0d want 2", ob_data.size()); else n_pass++;
    for (int i = 0; i < ob_data.size() && i < 2; i++) begin
      n_total++;
      if (ob_ch[i] != 0 || ob_data[i] !== 8'(i + 1) || ob_last[i] != (i == 1))
        $display("FAIL after_drop_beat%0d: got ch%0d %h last=%0d want ch0 %h last=%0d",
                 i, ob_ch[i], ob_data[i], ob_last[i], 8'(i + 1), (i == 1));
      else n_pass++;
    end
  endtask

  task automatic test_short();
    clr_mon();
    send_pkt(32'hE1EC0C0D, 3, -1, 0);
    idle(4);
    n_total++; if (n_drop != 1) $display("FAIL short_drop: got %0d want 1", n_drop); else n_pass++;
    n_total++; if (n_mv_any != 0) $display("FAIL short_mvalid: got %0d cycles want 0", n_mv_any); else n_pass++;
  endtask

  task automatic test_watchdog();
    clr_mon();
    send_pkt(32'hE1EC0C0D, 8, 5, 15);
    idle(6);
    n_total++; if (ob_data.size() != 2) $display("FAIL wd_beats: got %0d want 2", ob_data.size()); else n_pass++;
    for (int i = 0; i < ob_data.size() && i < 2; i++) begin
      n_total++;
      if (ob_ch[i] != 0 || ob_data[i] !== 8'(i + 1) || ob_last[i] != (i == 1))
        $display("FAIL wd_beat%0d: got ch%0d %h last=%0d want ch0 %h last=%0d",
                 i, ob_ch[i], ob_data[i], ob_last[i], 8'(i + 1), (i == 1));
      else n_pass++;
    end
    n_total++; if (n_to != 1) $display("FAIL wd_timeout: got %0d want 1", n_to); else n_pass++;
    n_total++; if (n_drop != 0) $display("FAIL wd_drop: got %0d want 0", n_drop); else n_pass++;
    clr_mon();
    send_pkt(32'hE1EC0C0D, 5, -1, 0);
    idle(4);
    n_total++;
    if (ob_data.size() != 1 || ob_data[0] !== 8'h01 || !ob_last[0] || ob_ch[0] != 0)
      $display("FAIL wd_recover: got %0d beats want 1 beat ch0 01 last", ob_data.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    clr_mon();
    send_byte(8'hE1, 1'b0);
    send_byte(8'hEC, 1'b0);
    send_byte(8'h0C, 1'b0);
    send_byte(8'h0D, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    sys_rst_n = 1'b0;
    @(posedge sys_clk);
    @(negedge sys_clk);
    n_total++; if (m_valid !== 2'b00) $display("FAIL mid_m_valid: got %b want 00", m_valid); else n_pass++;
    n_total++; if (m_last !== 1'b0) $display("FAIL mid_m_last: got %b want 0", m_last); else n_pass++;
    n_total++; if (m_data !== 8'h00) $display("FAIL mid_m_data: got %h want 00", m_data); else n_pass++;
    n_total++; if (s_ready !== 1'b0) $display("FAIL mid_s_ready: got %b want 0", s_ready); else n_pass++;
    n_total++; if (drop_pulse !== 1'b0 || timeout_pulse !== 1'b0)
      $display("FAIL mid_pulses: got %b%b want 00", drop_pulse, timeout_pulse); else n_pass++;
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    n_total++; if (s_ready !== 1'b1) $display("FAIL mid_rel_s_ready: got %b want 1", s_ready); else n_pass++;
    idle(1);
    clr_mon();
    send_pkt(32'hE1EC0C0D, 6, -1, 0);
    idle(5);
    n_total++; if (ob_data.size() != 2) $display("FAIL mid_beats: got %0d want 2", ob_data.size()); else n_pass++;
    for (int i = 0; i < ob_data.size() && i < 2; i++) begin
      n_total++;
      if (ob_ch[i] != 0 || ob_data[i] !== 8'(i + 1) || ob_last[i] != (i == 1))
        $display("FAIL mid_beat%0d: got ch%0d %h last=%0d want ch0 %h last=%0d",
                 i, ob_ch[i], ob_data[i], ob_last[i], 8'(i + 1), (i == 1));
      else n_pass++;
    end
    n_total++; if (n_drop != 0) $display("FAIL mid_drop: got %0d want 0", n_drop); else n_pass++;
`ifdef UDP_CHAN_DEMUX_STATS_EN
    n_total++; if (ch_pkt_cnt !== 32'h0000_0001) $display("FAIL mid_cnt: got %h want 00000001", ch_pkt_cnt); else n_pass++;
`endif
  endtask

  initial begin
    clr_mon();
    test_reset();
    test_fwd_ch0();
    test_backpressure();
    test_drop();
    test_short();
    test_watchdog();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

endmodule
